// File: rtl/spi_host_master.sv
// Host-side SPI master (mode 0, MSB first, 16-bit words) for the two-chip-select protocol:
// one command frame on spi_cs_cmd, then an optional full-duplex data frame on spi_cs_data.
module spi_host_master #(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] cmd_word,
   input  logic [7:0]  data_len,
   input  logic [15:0] tx_data,
   output logic        tx_req,
   output logic [15:0] rx_data,
   output logic        rx_valid,
   output logic        busy,
   output logic        done,
   output logic        spi_scl,
   output logic        spi_sdo,
   input  logic        spi_sdi,
   output logic        spi_cs_cmd,
   output logic        spi_cs_data
);

   typedef enum logic [3:0] {
      IDLE, CMD_SETUP, CMD_SHIFT, CMD_HOLD, GAP,
      DATA_SETUP, DATA_SHIFT, DATA_HOLD, DONE
   } state_e;

   localparam logic [15:0] HP_LAST  = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [4:0]  hp_q, hp_d;
   logic        scl_q, scl_d;
   logic [15:0] tx_sh_q, tx_sh_d;
   logic [15:0] rx_sh_q, rx_sh_d;
   logic [15:0] rx_data_q, rx_data_d;
   logic [7:0]  words_q, words_d;
   logic        rx_valid_q, rx_valid_d;
   logic        tx_load;
   logic        hp_tick;

   assign hp_tick = (cnt_q == HP_LAST);

   always_comb begin
      // NOTE: every variable gets its default before the case so no path can infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q + 16'd1;
      hp_d       = hp_q;
      scl_d      = scl_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      words_d    = words_q;
      rx_valid_d = 1'b0;
      tx_load    = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start) begin
               tx_sh_d = cmd_word;
               words_d = data_len;
               state_d = CMD_SETUP;
            end
         end
         CMD_SETUP: begin
            if (hp_tick) begin
               cnt_d   = '0;
               hp_d    = '0;
               state_d = CMD_SHIFT;
            end
         end
         CMD_SHIFT, DATA_SHIFT: begin
            if (hp_tick) begin
               cnt_d = '0;
               scl_d = ~scl_q;
               hp_d  = hp_q + 5'd1;
               // Rising edge samples the slave; falling edge advances the outgoing word.
               if (!scl_q) begin
                  if (state_q == DATA_SHIFT) rx_sh_d = {rx_sh_q[14:0], spi_sdi};
               end else begin
                  tx_sh_d = {tx_sh_q[14:0], 1'b0};
               end
               if (hp_q == 5'd31) begin
                  if (state_q == CMD_SHIFT) begin
                     state_d = CMD_HOLD;
                  end else begin
                     rx_data_d  = rx_sh_q;
                     rx_valid_d = 1'b1;
                     words_d    = words_q - 8'd1;
                     if (words_q > 8'd1) begin
                        tx_load = 1'b1;
                        tx_sh_d = tx_data;
                     end else begin
                        state_d = DATA_HOLD;
                     end
                  end
               end
            end
         end
         CMD_HOLD: begin
            if (hp_tick) begin
               cnt_d   = '0;
               state_d = (words_q != 8'd0) ? GAP : DONE;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = DATA_SETUP;
            end
         end
         DATA_SETUP: begin
            if (cnt_q == 16'd0) begin
               tx_load = 1'b1;
               tx_sh_d = tx_data;
            end
            if (hp_tick) begin
               cnt_d   = '0;
               hp_d    = '0;
               state_d = DATA_SHIFT;
            end
         end
         DATA_HOLD: begin
            if (hp_tick) begin
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         hp_q       <= '0;
         scl_q      <= 1'b0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         words_q    <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments only here, so every register sees pre-edge values.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hp_q       <= hp_d;
         scl_q      <= scl_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         words_q    <= words_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign spi_cs_cmd  = !(state_q inside {CMD_SETUP, CMD_SHIFT, CMD_HOLD});
   assign spi_cs_data = !(state_q inside {DATA_SETUP, DATA_SHIFT, DATA_HOLD});
   assign spi_scl     = scl_q;
   // The first data bit is presented from tx_data while the shift register is still loading.
   assign spi_sdo     = (spi_cs_cmd && spi_cs_data) ? 1'b0 :
                        (state_q == DATA_SETUP && cnt_q == 16'd0) ? tx_data[15] : tx_sh_q[15];
   assign tx_req      = tx_load;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign busy        = (state_q != IDLE) && (state_q != DONE);
   assign done        = (state_q == DONE);

endmodule

// File: tb/tb_spi_host_master.sv
// Directed bench for spi_host_master: slave model, event monitors and per-feature test tasks
// on a CLK_DIV=2 instance plus a CLK_DIV=5 instance for phase timing.
module tb_spi_host_master;
   localparam int DIV_A = 2;
   localparam int GAP_A = 2;
   localparam int DIV_B = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        start, tx_req, rx_valid, busy, done;
   logic        spi_scl, spi_sdo, spi_cs_cmd, spi_cs_data;
   logic        spi_sdi = 1'b0;
   logic [15:0] cmd_word, tx_data, rx_data;
   logic [7:0]  data_len;

   logic        b_start, b_tx_req, b_rx_valid, b_busy, b_done;
   logic        b_scl, b_sdo, b_cs_cmd, b_cs_data, b_sdi;
   logic [15:0] b_cmd_word, b_tx_data, b_rx_data;
   logic [7:0]  b_data_len;

   spi_host_master #(.CLK_DIV(DIV_A), .CS_GAP(GAP_A)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cmd_word(cmd_word), .data_len(data_len),
      .tx_data(tx_data), .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid),
      .busy(busy), .done(done), .spi_scl(spi_scl), .spi_sdo(spi_sdo), .spi_sdi(spi_sdi),
      .spi_cs_cmd(spi_cs_cmd), .spi_cs_data(spi_cs_data));

   spi_host_master #(.CLK_DIV(DIV_B), .CS_GAP(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .cmd_word(b_cmd_word), .data_len(b_data_len),
      .tx_data(b_tx_data), .tx_req(b_tx_req), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
      .busy(b_busy), .done(b_done), .spi_scl(b_scl), .spi_sdo(b_sdo), .spi_sdi(b_sdi),
      .spi_cs_cmd(b_cs_cmd), .spi_cs_data(b_cs_data));

   int n_checks = 0;
   int n_fail   = 0;

   // Stimulus tables written by the tests
   logic [15:0] tx_list [3];
   logic [15:0] rsp_list[3];
   logic        stream;
   int          tx_base, rsp_base;

   // Monitor state (written only by the monitors)
   int tx_total = 0, tx_req_cnt = 0, rx_cnt = 0, done_cnt = 0, both_low_cnt = 0;
   int data_low_total = 0, data_frames = 0, cmd_run = 0, last_cmd_len = 0;
   int gap_run = 0, last_gap = 0, since_rise = 0, scl_gap_err = 0;
   bit tx_pend = 0, rise_seen = 0;
   logic prev_cs_data = 1'b1, prev_scl = 1'b0;
   logic [15:0] rx_log[$];

   // Slave model state
   logic [15:0] s_cmd_cap = 16'h0, s_dcap = 16'h0, s_cur = 16'h0;
   int s_bits = 0, s_words = 0;
   bit s_in_frame = 0;
   logic [15:0] seen_q[$];

   // CLK_DIV=5 instance monitor state
   int b_run = 0, b_phase_n = 0, b_phase_err = 0, b_rise_n = 0, b_sdo_err = 0;
   int b_cmd_run = 0, b_cmd_len = 0, b_done_cnt = 0, b_tx_req_cnt = 0;
   bit b_fell = 0;
   logic b_prev_scl = 1'b0, b_prev_sdo = 1'b0;

   always_comb begin
      tx_data = 16'h0;
      if (stream) tx_data = 16'(tx_total - tx_base);
      else if (tx_total - tx_base >= 0 && tx_total - tx_base < 3) tx_data = tx_list[tx_total - tx_base];
   end

   function automatic logic [15:0] rsp_word(input int i);
      if (stream) return ~16'(i);
      if (i >= 0 && i < 3) return rsp_list[i];
      return 16'h0;
   endfunction

   always @(posedge spi_scl) if (!spi_cs_cmd) s_cmd_cap = {s_cmd_cap[14:0], spi_sdo};

   always @(posedge spi_scl or negedge spi_scl or negedge spi_cs_data or posedge spi_cs_data) begin
      if (spi_cs_data !== 1'b0) begin
         s_in_frame = 0;
      end else if (!s_in_frame) begin
         s_in_frame = 1; s_bits = 0;
         s_cur = rsp_word(s_words - rsp_base); s_words++;
         spi_sdi = s_cur[15];
      end else if (spi_scl) begin
         s_dcap = {s_dcap[14:0], spi_sdo};
         s_bits++;
         if (s_bits == 16) seen_q.push_back(s_dcap);
      end else if (s_bits == 16) begin
         s_bits = 0;
         s_cur = rsp_word(s_words - rsp_base); s_words++;
         spi_sdi = s_cur[15];
      end else begin
         spi_sdi = s_cur[15 - s_bits];
      end
   end

   always @(negedge clk) begin
      if (tx_pend) begin tx_total++; tx_pend = 0; end
      if (tx_req) begin tx_req_cnt++; tx_pend = 1; end
      if (rx_valid) begin rx_cnt++; rx_log.push_back(rx_data); end
      if (done) done_cnt++;
      if (!spi_cs_cmd && !spi_cs_data) both_low_cnt++;
      if (!spi_cs_data) data_low_total++;
      if (!spi_cs_data && prev_cs_data) data_frames++;
      if (!spi_cs_cmd) cmd_run++;
      else if (cmd_run != 0) begin last_cmd_len = cmd_run; cmd_run = 0; end
      if (spi_cs_cmd && spi_cs_data && busy) gap_run++;
      else begin
         if (!spi_cs_data && gap_run != 0) last_gap = gap_run;
         gap_run = 0;
      end
      if (!spi_cs_data) begin
         if (spi_scl && !prev_scl) begin
            if (rise_seen && since_rise != 2 * DIV_A) scl_gap_err++;
            rise_seen = 1; since_rise = 0;
         end
      end else rise_seen = 0;
      since_rise++;
      prev_cs_data = spi_cs_data;
      prev_scl = spi_scl;
   end

   always @(negedge clk) begin
      if (b_scl != b_prev_scl) begin
         if (b_prev_scl || b_fell) begin
            b_phase_n++;
            if (b_run != DIV_B) b_phase_err++;
         end
         if (b_prev_scl) b_fell = 1;
         else begin
            b_rise_n++;
            if (b_sdo != b_prev_sdo) b_sdo_err++;
         end
         b_run = 0;
      end
      if (b_cs_cmd && b_cs_data) b_fell = 0;
      b_run++;
      if (!b_cs_cmd) b_cmd_run++;
      else if (b_cmd_run != 0) begin b_cmd_len = b_cmd_run; b_cmd_run = 0; end
      if (b_done) b_done_cnt++;
      if (b_tx_req) b_tx_req_cnt++;
      b_prev_scl = b_scl;
      b_prev_sdo = b_sdo;
   end

   task automatic do_start(input logic [15:0] cmd, input logic [7:0] len);
      @(negedge clk);
      cmd_word = cmd; data_len = len; start = 1'b1;
      @(negedge clk);
      start = 1'b0; cmd_word = 16'hDEAD; data_len = 8'hEE;
   endtask

   task automatic wait_done(input int max_cycles, input string name);
      int k = 0;
      while (!done && k < max_cycles) begin @(negedge clk); k++; end
      n_checks++;
      if (!done) begin n_fail++; $display("FAIL %s: done not seen within %0d cycles", name, max_cycles); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({spi_cs_cmd, spi_cs_data} !== 2'b11) begin
         n_fail++; $display("FAIL reset_cs: got %b expected 11", {spi_cs_cmd, spi_cs_data});
      end
      n_checks++;
      if ({spi_scl, spi_sdo} !== 2'b00) begin
         n_fail++; $display("FAIL reset_scl_sdo: got %b expected 00", {spi_scl, spi_sdo});
      end
      n_checks++;
      if ({busy, done, tx_req, rx_valid} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, tx_req, rx_valid});
      end
      n_checks++;
      if (rx_data !== 16'h0) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 0000", rx_data); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_cmd_only();
      int d0 = done_cnt, t0 = tx_req_cnt, l0 = data_low_total;
      do_start(16'h8001, 8'd0);
      wait_done(200, "cmd_only_done");
      repeat (10) @(negedge clk);
      n_checks++;
      if (s_cmd_cap !== 16'h8001) begin n_fail++; $display("FAIL cmd_only_word: got %h expected 8001", s_cmd_cap); end
      n_checks++;
      if (last_cmd_len != 34 * DIV_A) begin
         n_fail++; $display("FAIL cmd_only_cs_len: got %0d expected %0d", last_cmd_len, 34 * DIV_A);
      end
      n_checks++;
      if (data_low_total - l0 != 0) begin n_fail++; $display("FAIL cmd_only_cs_data: low %0d cycles expected 0", data_low_total - l0); end
      n_checks++;
      if (tx_req_cnt - t0 != 0) begin n_fail++; $display("FAIL cmd_only_tx_req: got %0d expected 0", tx_req_cnt - t0); end
      n_checks++;
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL cmd_only_done_cnt: got %0d expected 1", done_cnt - d0); end
   endtask

   task automatic test_data_frame(input string name);
      int t0 = tx_req_cnt, r0 = rx_cnt, sb = seen_q.size(), rb = rx_log.size();
      tx_list  = '{16'h1234, 16'hABCD, 16'h0F0F};
      rsp_list = '{16'h5555, 16'hAAAA, 16'h0001};
      stream = 1'b0; tx_base = tx_total; rsp_base = s_words;
      do_start(16'h0003, 8'd3);
      wait_done(800, name);
      n_checks++;
      if (s_cmd_cap !== 16'h0003) begin n_fail++; $display("FAIL %s cmd: got %h expected 0003", name, s_cmd_cap); end
      n_checks++;
      if (seen_q.size() - sb != 3) begin
         n_fail++; $display("FAIL %s slave_words: got %0d expected 3", name, seen_q.size() - sb);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (seen_q[sb + i] !== tx_list[i]) begin
               n_fail++; $display("FAIL %s slave_word%0d: got %h expected %h", name, i, seen_q[sb + i], tx_list[i]);
            end
         end
      end
      n_checks++;
      if (rx_cnt - r0 != 3) begin
         n_fail++; $display("FAIL %s rx_valid_cnt: got %0d expected 3", name, rx_cnt - r0);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rx_log[rb + i] !== rsp_list[i]) begin
               n_fail++; $display("FAIL %s rx_data%0d: got %h expected %h", name, i, rx_log[rb + i], rsp_list[i]);
            end
         end
      end
      n_checks++;
      if (tx_req_cnt - t0 != 3) begin n_fail++; $display("FAIL %s tx_req_cnt: got %0d expected 3", name, tx_req_cnt - t0); end
      n_checks++;
      if (last_gap < GAP_A) begin n_fail++; $display("FAIL %s cs_gap: got %0d expected >= %0d", name, last_gap, GAP_A); end
      n_checks++;
      if (both_low_cnt != 0) begin n_fail++; $display("FAIL %s both_cs_low: got %0d cycles expected 0", name, both_low_cnt); end
   endtask

   task automatic test_start_storm();
      int d0 = done_cnt, t0 = tx_req_cnt, f0 = data_frames, k = 0;
      tx_list = '{16'h4242, 16'h0, 16'h0};
      stream = 1'b0; tx_base = tx_total; rsp_base = s_words;
      @(negedge clk);
      cmd_word = 16'hC3A5; data_len = 8'd1; start = 1'b1;
      do begin
         @(negedge clk);
         cmd_word = 16'($urandom); data_len = 8'($urandom_range(2, 255)); k++;
      end while (!done && k < 400);
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      n_checks++;
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL storm_done_cnt: got %0d expected 1", done_cnt - d0); end
      n_checks++;
      if (s_cmd_cap !== 16'hC3A5) begin n_fail++; $display("FAIL storm_cmd: got %h expected c3a5", s_cmd_cap); end
      n_checks++;
      if (tx_req_cnt - t0 != 1) begin n_fail++; $display("FAIL storm_tx_req: got %0d expected 1", tx_req_cnt - t0); end
      n_checks++;
      if (data_frames - f0 != 1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL storm_frames: got %0d busy %b expected 1 busy 0", data_frames - f0, busy);
      end
   endtask

   task automatic test_reset_mid();
      int k = 0;
      tx_list = '{16'h1111, 16'h2222, 16'h3333};
      stream = 1'b0; tx_base = tx_total; rsp_base = s_words;
      do_start(16'h7E7E, 8'd3);
      while (spi_cs_data && k < 300) begin @(negedge clk); k++; end
      repeat (40) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({spi_cs_cmd, spi_cs_data, spi_scl, busy} !== 4'b1100) begin
         n_fail++; $display("FAIL mid_reset: cs_cmd,cs_data,scl,busy got %b expected 1100",
                            {spi_cs_cmd, spi_cs_data, spi_scl, busy});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      test_data_frame("after_reset");
   endtask

   task automatic test_stream();
      int t0 = tx_req_cnt, r0 = rx_cnt, f0 = data_frames, sb = seen_q.size(), rb = rx_log.size();
      int e0 = scl_gap_err;
      stream = 1'b1; tx_base = tx_total; rsp_base = s_words;
      do_start(16'h00FF, 8'd255);
      wait_done(20000, "stream_done");
      n_checks++;
      if (rx_cnt - r0 != 255) begin n_fail++; $display("FAIL stream_rx_valid: got %0d expected 255", rx_cnt - r0); end
      n_checks++;
      if (tx_req_cnt - t0 != 255) begin n_fail++; $display("FAIL stream_tx_req: got %0d expected 255", tx_req_cnt - t0); end
      n_checks++;
      if (data_frames - f0 != 1) begin n_fail++; $display("FAIL stream_cs_frames: got %0d expected 1", data_frames - f0); end
      n_checks++;
      if (scl_gap_err != e0) begin n_fail++; $display("FAIL stream_scl_gap: %0d irregular periods expected 0", scl_gap_err - e0); end
      n_checks++;
      if (seen_q.size() - sb != 255) begin
         n_fail++; $display("FAIL stream_slave_words: got %0d expected 255", seen_q.size() - sb);
      end else if (seen_q[sb] !== 16'd0 || seen_q[sb + 254] !== 16'd254) begin
         n_fail++; $display("FAIL stream_slave_data: first %h last %h expected 0000 00fe", seen_q[sb], seen_q[sb + 254]);
      end
      n_checks++;
      if (rx_log.size() - rb != 255) begin
         n_fail++; $display("FAIL stream_rx_log: got %0d words expected 255", rx_log.size() - rb);
      end else if (rx_log[rb + 100] !== 16'hFF9B || rx_log[rb + 254] !== 16'hFF01) begin
         n_fail++; $display("FAIL stream_rx_data: word100 %h word254 %h expected ff9b ff01", rx_log[rb + 100], rx_log[rb + 254]);
      end
      stream = 1'b0;
   endtask

   task automatic test_clkdiv5();
      int p0 = b_phase_n, pe0 = b_phase_err, se0 = b_sdo_err, r0 = b_rise_n, d0 = b_done_cnt, t0 = b_tx_req_cnt, k = 0;
      @(negedge clk);
      b_cmd_word = 16'h00F0; b_data_len = 8'd2; b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0; b_cmd_word = 16'hFFFF;
      while (!b_done && k < 2000) begin @(negedge clk); k++; end
      repeat (5) @(negedge clk);
      n_checks++;
      if (b_done_cnt - d0 != 1) begin n_fail++; $display("FAIL div5_done: got %0d expected 1", b_done_cnt - d0); end
      n_checks++;
      if (b_phase_n - p0 < 90 || b_phase_err != pe0) begin
         n_fail++; $display("FAIL div5_phases: %0d phases, %0d not %0d cycles", b_phase_n - p0, b_phase_err - pe0, DIV_B);
      end
      n_checks++;
      if (b_rise_n - r0 != 48 || b_sdo_err != se0) begin
         n_fail++; $display("FAIL div5_sdo_at_rise: %0d rises, %0d with sdo change expected 48 and 0", b_rise_n - r0, b_sdo_err - se0);
      end
      n_checks++;
      if (b_cmd_len != 34 * DIV_B) begin n_fail++; $display("FAIL div5_cmd_len: got %0d expected %0d", b_cmd_len, 34 * DIV_B); end
      n_checks++;
      if (b_tx_req_cnt - t0 != 2) begin n_fail++; $display("FAIL div5_tx_req: got %0d expected 2", b_tx_req_cnt - t0); end
   endtask

   initial begin
      start = 1'b0; cmd_word = 16'h0; data_len = 8'd0;
      b_start = 1'b0; b_cmd_word = 16'h0; b_data_len = 8'd0; b_tx_data = 16'hA5C3; b_sdi = 1'b1;
      stream = 1'b0; tx_base = 0; rsp_base = 0;
      tx_list = '{16'h0, 16'h0, 16'h0};
      rsp_list = '{16'h0, 16'h0, 16'h0};
      test_reset();
      test_cmd_only();
      test_data_frame("data_frame");
      test_start_storm();
      test_reset_mid();
      test_clkdiv5();
      test_stream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/spi_host_master.md
Name: spi_host_master

Overview:
- Host-side SPI master that drives the two-chip-select command/data protocol the FPGA SPI interface listens on.
- Each transaction is one 16-bit command frame on spi_cs_cmd, then an optional data frame on spi_cs_data carrying data_len full-duplex 16-bit words.
- Serves as an FPGA-resident host for bridging and loopback, and as the stimulus/response engine in system benches.

Parameters:
- CLK_DIV, 4: clk cycles per SCL half-period. Legal values are 2 and above.
- CS_GAP, 2: idle clk cycles with both CS high between the command frame and the data frame. Legal values are 1 and above.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a transaction; ignored while busy
- cmd_word  input  16  command word; latched on an accepted start
- data_len  input  8  number of data words; latched on start; 0 means command-only
- tx_data  input  16  next data word to send; sampled in the cycle tx_req is high
- tx_req  output  1  1-cycle pulse: tx_data consumed
- rx_data  output  16  last received data word; held until the next word
- rx_valid  output  1  1-cycle pulse: rx_data updated
- busy  output  1  high from the accepted start until done
- done  output  1  1-cycle pulse at transaction end
- spi_scl  output  1  serial clock, idle low
- spi_sdo  output  1  master out, to the slave data input
- spi_sdi  input  1  master in, from the slave data output
- spi_cs_cmd  output  1  command chip select, active low
- spi_cs_data  output  1  data chip select, active low

Behaviour:
- Reset values (asynchronous, immediate, including mid-transfer): spi_cs_cmd=1, spi_cs_data=1, spi_scl=0, spi_sdo=0, busy=0, done=0, tx_req=0, rx_valid=0, rx_data=0, FSM=IDLE. Any partial word is discarded.
- SPI mode 0, MSB first, 16 bits per word:
  - spi_sdo is valid before each rising edge.
  - spi_sdi is sampled on each rising edge.
  - spi_sdo changes only after a falling edge.
- Half-period timer counts CLK_DIV clk cycles; SCL toggles at each terminal count.
- FSM states:
  - IDLE: on start, latch cmd_word and data_len, set busy, go to CMD_SETUP.
  - CMD_SETUP: spi_cs_cmd=0; spi_sdo=cmd[15]; wait one half-period.
  - CMD_SHIFT: 16 SCL periods (32 half-periods). spi_sdi is ignored in this state.
  - CMD_HOLD: SCL low for one half-period, then spi_cs_cmd=1. Go to GAP if data_len>0, else DONE.
  - GAP: both CS high for CS_GAP cycles.
  - DATA_SETUP: in the first cycle, pulse tx_req and load the shift register from tx_data. spi_cs_data=0; spi_sdo=word[15]; wait one half-period.
  - DATA_SHIFT: 16 SCL periods per word. On the 16th falling edge:
    - If words remain: pulse tx_req, load the next tx_data, and drive its MSB. Continue without a gap; spi_cs_data stays low.
    - If this was the last word: go to DATA_HOLD.
  - DATA_HOLD: one half-period with SCL low, then spi_cs_data=1. Go to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- rx: the shift register captures spi_sdi at each rising edge. At the 16th falling edge of each data word: rx_data <= captured word, rx_valid=1 for one cycle.
- Word counter is 8 bits. It counts down from data_len and never wraps; data_len=255 sends exactly 255 words.
- spi_cs_cmd and spi_cs_data are never low simultaneously.
- Command frame length: (34*CLK_DIV) clk cycles with spi_cs_cmd low.
- start asserted during the DONE cycle is ignored. start is accepted only in IDLE, and busy stays high until DONE.
- tx_req, rx_valid, and done are each exactly one cycle wide. rx_valid for the last word precedes done.

Test Plan:
- Reset → check all reset values while rst_n=0. Assert rst_n low mid-DATA_SHIFT → both CS high and SCL low in the same cycle. A subsequent start completes normally.
- CLK_DIV=2, cmd_word=0x8001, data_len=0 → slave model captures 0x8001. spi_cs_cmd low for 68 cycles; spi_cs_data never low; 0 tx_req pulses; one done pulse.
- CLK_DIV=2, CS_GAP=2, cmd_word=0x0003, data_len=3, tx words 0x1234/0xABCD/0x0F0F, slave returns 0x5555/0xAAAA/0x0001:
  - slave sees 0x1234, 0xABCD, 0x0F0F;
  - rx_valid pulses 3 times, with rx_data 0x5555, 0xAAAA, 0x0001;
  - tx_req pulses 3 times;
  - both CS high for at least 2 cycles between frames.
- start pulsed every cycle while busy → exactly one transaction occurs; cmd_word changes after start do not alter the bits sent.
- CLK_DIV=5 → SCL high and low phases are each 5 cycles. No spi_sdo transition coincides with a rising SCL edge (checked by assertion).
- data_len=255, streaming tx_data=counter → 255 rx_valid pulses and 255 tx_req pulses. spi_cs_data stays continuously low with no SCL gap between words.
